if_id_pipe_reg: RTL and testbench

Parametrised IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Decouples fetch from decode so that back-pressure does not create a combinational ready path into fetch.
- Supports hold on back-pressure and flush with bubble insertion; bubbles present a canonical NOP.
- Sits between the fetch unit and the decoder; generalises to any stage boundary through the payload parameters.

---
 rtl/if_id_pipe_reg_pkg.sv | 23 ++
 rtl/if_id_pipe_reg_pipe_entry.sv | 27 ++
 rtl/if_id_pipe_reg.sv | 106 ++++++++++
 tb/tb_if_id_pipe_reg.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/if_id_pipe_reg_pkg.sv
// Shared types and defaults for the IF/ID pipeline register and its entries.
// Payload layout and state encoding are common to the top and the bench.
package if_id_pipe_reg_pkg;

  localparam int DEF_ILEN = 32;
  localparam int DEF_XLEN = 32;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h00000013;
  localparam logic [31:0] DEF_RESET_PC  = 32'h00000000;

  typedef struct packed {
    logic                fault;
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] instr;
  } fetch_payload_t;

  // Encoding equals the number of held entries, so it doubles as occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/if_id_pipe_reg_pipe_entry.sv
// One payload slot with a valid bit: enable load, synchronous clear,
// asynchronous active-low reset. Clear wins over load.
module pipe_entry #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Main entry M drives decode; skid entry S catches an accept that lands during a stall.
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int               ILEN      = DEF_ILEN,
  parameter int               XLEN      = DEF_XLEN,
  parameter logic [ILEN-1:0]  NOP_INSTR = ILEN'(DEF_NOP_INSTR),
  parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            fault_i,
  output logic            ready_o,
  output logic            valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fault_o,
  input  logic            ready_i,
  input  logic            flush_i,
  output logic [1:0]      occupancy_o
);

  localparam int PW = ILEN + XLEN + 1;

  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } payload_t;

  payload_t in_pl, m_d, m_q, s_q;
  logic     m_valid, s_valid;
  logic     load_m, clr_m, load_s, clr_s;
  logic     accept, issue, ready_q;
  state_e   state, state_d;

  assign in_pl  = '{fault: fault_i, pc: pc_i, instr: instr_i};
  assign state  = m_valid ? (s_valid ? TWO : ONE) : EMPTY;
  assign accept = valid_i & ready_q;
  assign issue  = m_valid & ready_i;

  always_comb begin
    state_d = state;
    load_m  = 1'b0;
    clr_m   = 1'b0;
    load_s  = 1'b0;
    clr_s   = 1'b0;
    m_d     = in_pl;
    if (flush_i) begin
      clr_m   = 1'b1;
      clr_s   = 1'b1;
      state_d = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          load_m  = 1'b1;
          state_d = ONE;
        end
        ONE: if (accept && issue) begin
          load_m = 1'b1;
        end else if (accept) begin
          load_s  = 1'b1;
          state_d = TWO;
        end else if (issue) begin
          clr_m   = 1'b1;
          state_d = EMPTY;
        end
        TWO: if (issue) begin
          load_m  = 1'b1;
          m_d     = s_q;
          clr_s   = 1'b1;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Registered ready keeps decode back-pressure off the fetch-side timing path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b1;
    else      ready_q <= (state_d != TWO);
  end

  pipe_entry #(.W(PW)) u_main (
    .clk(clk), .rst(rst), .clr(clr_m), .load(load_m),
    .d(m_d), .valid(m_valid), .q(m_q)
  );

  pipe_entry #(.W(PW)) u_skid (
    .clk(clk), .rst(rst), .clr(clr_s), .load(load_s),
    .d(in_pl), .valid(s_valid), .q(s_q)
  );

  assign ready_o     = ready_q;
  assign valid_o     = m_valid;
  assign instr_o     = m_valid ? m_q.instr : NOP_INSTR;
  assign pc_o        = m_valid ? m_q.pc    : RESET_PC;
  assign fault_o     = m_valid & m_q.fault;
  assign occupancy_o = 2'(state);

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        fault_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ready_o, valid_o, fault_o;
  logic [31:0] instr_o, pc_o;
  logic [1:0]  occupancy_o;

  int     checks = 0;
  int     errors = 0;
  entry_t model_q[$];

  if_id_pipe_reg dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i), .fault_i(fault_i),
    .ready_o(ready_o),
    .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .fault_o(fault_o),
    .ready_i(ready_i), .flush_i(flush_i), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Compares every output against what the held-entry queue implies.
  task automatic checkAll();
    logic ev;
    ev = (model_q.size() > 0);
    checkOutput("valid_o", 64'(valid_o), 64'(ev));
    checkOutput("instr_o", 64'(instr_o), ev ? 64'(model_q[0].instr) : 64'(NOP));
    checkOutput("pc_o", 64'(pc_o), ev ? 64'(model_q[0].pc) : 64'd0);
    checkOutput("fault_o", 64'(fault_o), ev ? 64'(model_q[0].fault) : 64'd0);
    checkOutput("ready_o", 64'(ready_o), 64'(model_q.size() < 2));
    checkOutput("occupancy_o", 64'(occupancy_o), 64'(model_q.size()));
  endtask

  // Drives one cycle of inputs (called just after a falling edge), then updates the model.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] p,
                               input logic f, input logic rdy, input logic fl);
    logic   acc, iss;
    entry_t e;
    valid_i = v; instr_i = ins; pc_i = p; fault_i = f; ready_i = rdy; flush_i = fl;
    acc = v && (model_q.size() < 2);
    iss = rdy && (model_q.size() > 0);
    e.instr = ins; e.pc = p; e.fault = f;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (iss) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
    end
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    // Power-on reset
    #3 rst = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(valid_o), 64'd0);
    checkOutput("rst_instr", 64'(instr_o), 64'(NOP));
    checkOutput("rst_ready", 64'(ready_o), 64'd1);
    checkOutput("rst_occ", 64'(occupancy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Streaming: 8 back-to-back transfers, each visible the cycle after acceptance
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, $urandom, 32'h100 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
      checkOutput("stream_pc", 64'(pc_o), 64'(32'h100 + 32'(4 * i)));
      checkOutput("stream_valid", 64'(valid_o), 64'd1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("stream_drain", 64'(valid_o), 64'd0);

    // Skid: stall while a second instruction is accepted
    applyStimulus(1'b1, $urandom, 32'h200, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, $urandom, 32'h204, 1'b0, 1'b0, 1'b0);
    checkOutput("skid_occ", 64'(occupancy_o), 64'd2);
    checkOutput("skid_ready", 64'(ready_o), 64'd0);
    checkOutput("skid_pc0", 64'(pc_o), 64'h200);
    applyStimulus(1'b1, $urandom, 32'h208, 1'b0, 1'b0, 1'b0);
    checkOutput("skid_hold", 64'(pc_o), 64'h200);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("skid_pc1", 64'(pc_o), 64'h204);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("skid_empty", 64'(valid_o), 64'd0);

    // Flush in TWO with a simultaneous valid input
    applyStimulus(1'b1, $urandom, 32'h2A0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, $urandom, 32'h2A4, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_pre_occ", 64'(occupancy_o), 64'd2);
    applyStimulus(1'b1, 32'hDEADBEEF, 32'h300, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_valid", 64'(valid_o), 64'd0);
    checkOutput("flush_instr", 64'(instr_o), 64'(NOP));
    checkOutput("flush_occ", 64'(occupancy_o), 64'd0);
    checkOutput("flush_ready", 64'(ready_o), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_no_300", 64'(valid_o && pc_o == 32'h300), 64'd0);

    // Fault tag travels with its instruction only
    applyStimulus(1'b1, $urandom, 32'h400, 1'b1, 1'b1, 1'b0);
    checkOutput("fault_set", 64'(fault_o), 64'd1);
    checkOutput("fault_pc", 64'(pc_o), 64'h400);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    checkOutput("fault_bubble", 64'(fault_o), 64'd0);

    // Asynchronous reset while two entries are held
    applyStimulus(1'b1, $urandom, 32'h500, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, $urandom, 32'h504, 1'b0, 1'b0, 1'b0);
    checkOutput("arst_pre_occ", 64'(occupancy_o), 64'd2);
    #2 rst = 1'b0;
    #1;
    model_q.delete();
    checkOutput("arst_valid", 64'(valid_o), 64'd0);
    checkOutput("arst_instr", 64'(instr_o), 64'(NOP));
    checkOutput("arst_pc", 64'(pc_o), 64'd0);
    checkOutput("arst_ready", 64'(ready_o), 64'd1);
    checkOutput("arst_occ", 64'(occupancy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Random traffic against the queue model
    for (int i = 0; i < 10000; i++) begin
      applyStimulus($urandom_range(99) < 70, $urandom, $urandom, 1'($urandom),
                    $urandom_range(99) < 65, $urandom_range(99) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
